// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and constants for the two-requester BRAM arbiter.
package bram_arb_pkg;
  typedef enum logic [1:0] {IDLE, G0, G1} state_e;
  typedef logic req_id_t;
  localparam int BURST_MAX_DEF = 4;
  localparam logic [3:0] BRAM_WE_READ = 4'b0000;
  function automatic state_e grant_state(input req_id_t id);
    return id ? G1 : G0;
  endfunction
endpackage

// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: requester handshakes plus the BRAM port, bundled for the arbiter.
interface bram_arbiter_if #(parameter int ADDR_W = 13);
  logic              r0_valid, r1_valid;
  logic              r0_ready, r1_ready;
  logic [3:0]        r0_we, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [31:0]       r0_wdata, r1_wdata;
  logic              r0_rvalid, r1_rvalid;
  logic [31:0]       r0_rdata, r1_rdata;
  logic [3:0]        WE0;
  logic              EN0;
  logic [31:0]       Di0, A0, Do0;
  modport slave (
    input  r0_valid, r1_valid, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, Do0,
    output r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, WE0, EN0, Di0, A0
  );
  modport master (
    output r0_valid, r1_valid, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata, Do0,
    input  r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, WE0, EN0, Di0, A0
  );
endinterface

// File: rtl/bram_arb_resp.sv
// bram_arb_resp: one-deep response tracker routing BRAM read data to the issuing requester.
module bram_arb_resp
  import bram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_i,
  input  req_id_t     id_i,
  input  logic        rd_i,
  input  logic [31:0] do_i,
  output logic [1:0]  rvalid_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o
);
  logic    resp_v_q, resp_v_d;
  req_id_t resp_id_q, resp_id_d;
  logic    resp_rd_q, resp_rd_d;
  logic [31:0] rd_data;

  assign resp_v_d  = acc_i;
  assign resp_id_d = id_i;
  assign resp_rd_d = rd_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_v_q  <= 1'b0;
      resp_id_q <= 1'b0;
      resp_rd_q <= 1'b0;
    end else begin
      resp_v_q  <= resp_v_d;
      resp_id_q <= resp_id_d;
      resp_rd_q <= resp_rd_d;
    end
  end

  // Old data returned by the BRAM on a write is discarded here.
  assign rd_data  = (resp_v_q && resp_rd_q) ? do_i : 32'h0;
  assign rvalid_o = {resp_v_q & resp_id_q, resp_v_q & ~resp_id_q};
  assign rdata0_o = resp_id_q ? 32'h0 : rd_data;
  assign rdata1_o = resp_id_q ? rd_data : 32'h0;
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: bounded-burst arbiter for the shared user BRAM (Wishbone = r0, FIR mover = r1).
// Define BRAM_ARB_RR_EN for round-robin tie breaking; default is fixed priority to r0.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic           CLK,
  input  logic           RST_N,
  bram_arbiter_if.slave  bus
);
  localparam logic [3:0] LAST = 4'(BURST_MAX - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  v;
  req_id_t     owner, tie_win;
  logic        active, own_v, oth_v, acc, last;
  logic [3:0]  sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  rvalid;

`ifdef BRAM_ARB_RR_EN
  req_id_t rr_q, rr_d;
  assign tie_win = ~rr_q;
  assign rr_d    = active ? owner : rr_q;
  always_ff @(posedge CLK) rr_q <= RST_N ? rr_d : 1'b0;
`else
  assign tie_win = 1'b0;
`endif

  assign v      = {bus.r1_valid, bus.r0_valid};
  // IDLE resolves the grant combinationally so the first beat issues without a bubble.
  assign owner  = (state_q == G0) ? 1'b0 : (state_q == G1) ? 1'b1 : (&v) ? tie_win : v[1];
  assign active = RST_N && (state_q != IDLE || |v);
  assign own_v  = v[owner];
  assign oth_v  = v[~owner];
  assign acc    = active && own_v;
  assign last   = cnt_q == LAST;

  assign sel_we    = owner ? bus.r1_we    : bus.r0_we;
  assign sel_addr  = owner ? bus.r1_addr  : bus.r0_addr;
  assign sel_wdata = owner ? bus.r1_wdata : bus.r0_wdata;

  assign bus.r0_ready = active && !owner;
  assign bus.r1_ready = active && owner;
  assign bus.EN0      = acc;
  assign bus.WE0      = acc ? sel_we : BRAM_WE_READ;
  assign bus.Di0      = active ? sel_wdata : 32'h0;
  assign bus.A0       = active ? {{(32-ADDR_W){1'b0}}, sel_addr} : 32'h0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (active) begin
      if (!own_v) begin
        state_d = oth_v ? grant_state(~owner) : IDLE;
        cnt_d   = 4'd0;
      end else if (last && oth_v) begin
        state_d = grant_state(~owner);
        cnt_d   = 4'd0;
      end else begin
        state_d = grant_state(owner);
        cnt_d   = last ? cnt_q : cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  bram_arb_resp u_resp (
    .clk      (CLK),
    .rst_n    (RST_N),
    .acc_i    (acc),
    .id_i     (owner),
    .rd_i     (sel_we == BRAM_WE_READ),
    .do_i     (bus.Do0),
    .rvalid_o (rvalid),
    .rdata0_o (bus.r0_rdata),
    .rdata1_o (bus.r1_rdata)
  );

  assign bus.r0_rvalid = rvalid[0];
  assign bus.r1_rvalid = rvalid[1];
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed checks of grant, burst bounding, response routing and reset.
module tb_bram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  bram_arbiter_if #(.ADDR_W(13)) bus ();

  bram_arbiter #(.ADDR_W(13), .BURST_MAX(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  // Single-port BRAM model: registered read, byte-enabled write, old data out on writes.
  always @(posedge clk) begin
    if (bus.EN0) begin
      bus.Do0 <= mem[bus.A0[12:0]];
      for (int b = 0; b < 4; b++)
        if (bus.WE0[b]) mem[bus.A0[12:0]][8*b +: 8] <= bus.Di0[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic v, input logic [3:0] we, input logic [12:0] a, input logic [31:0] d);
    bus.r0_valid = v; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
  endtask

  task automatic req1(input logic v, input logic [3:0] we, input logic [12:0] a, input logic [31:0] d);
    bus.r1_valid = v; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
  endtask

  initial begin
    logic exp_own;
    rst_n = 1'b0;
    req0(0, 4'h0, 13'd0, 32'h0);
    req1(0, 4'h0, 13'd0, 32'h0);
    tick();
    tick();
    chk("rst_ready", {bus.r1_ready, bus.r0_ready}, 2'b00);
    chk("rst_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, 2'b00);
    chk("rst_rdata", {bus.r1_rdata, bus.r0_rdata}, 64'h0);
    chk("rst_en_we", {bus.EN0, bus.WE0}, 5'h0);
    chk("rst_a0_di0", {bus.A0, bus.Di0}, 64'h0);
    chk("rst_state", 64'(dut.state_q), 64'(bram_arb_pkg::IDLE));
    rst_n = 1'b1;
    tick();
    // Preload RAM[5] and RAM[7] through r0 full-word writes.
    req0(1, 4'hF, 13'd5, 32'hDEADBEEF);
    #1;
    chk("wr_ready", {bus.r1_ready, bus.r0_ready}, 2'b01);
    chk("wr_bram", {bus.EN0, bus.WE0, bus.A0}, {1'b1, 4'hF, 32'd5});
    tick();
    chk("wr_resp", {bus.r1_rvalid, bus.r0_rvalid, bus.r0_rdata}, {2'b01, 32'h0});
    req0(1, 4'hF, 13'd7, 32'h11223344);
    tick();
    req0(0, 4'h0, 13'd0, 32'h0);
    tick();
    // Single read
    req0(1, 4'h0, 13'd5, 32'h0);
    #1;
    chk("rd_ready", {bus.r1_ready, bus.r0_ready}, 2'b01);
    tick();
    chk("rd_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, 2'b01);
    chk("rd_rdata", {bus.r1_rdata, bus.r0_rdata}, {32'h0, 32'hDEADBEEF});
    req0(0, 4'h0, 13'd0, 32'h0);
    tick();
    // Byte write from r1, then read back
    req1(1, 4'b0010, 13'd7, 32'h0000AB00);
    #1;
    chk("bw_ready", {bus.r1_ready, bus.r0_ready}, 2'b10);
    chk("bw_bram", {bus.WE0, bus.Di0}, {4'b0010, 32'h0000AB00});
    tick();
    chk("bw_resp", {bus.r1_rvalid, bus.r0_rvalid, bus.r1_rdata}, {2'b10, 32'h0});
    req1(1, 4'h0, 13'd7, 32'h0);
    tick();
    chk("bw_rd", {bus.r1_rvalid, bus.r0_rvalid, bus.r1_rdata}, {2'b10, 32'h1122AB44});
    req1(0, 4'h0, 13'd0, 32'h0);
    tick();
    // Contention: r0 starts alone, r1 joins one cycle later; expect 0000 1111 00
    req0(1, 4'h0, 13'd5, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i == 1) req1(1, 4'h0, 13'd7, 32'h0);
      exp_own = (i >= 4 && i < 8);
      #1;
      chk($sformatf("cont_grant%0d", i), {bus.r1_ready, bus.r0_ready, bus.EN0}, {exp_own, !exp_own, 1'b1});
      tick();
      chk($sformatf("cont_rvalid%0d", i), {bus.r1_rvalid, bus.r0_rvalid}, {exp_own, !exp_own});
      chk($sformatf("cont_rdata%0d", i), {bus.r1_rdata, bus.r0_rdata},
          exp_own ? {32'h1122AB44, 32'h0} : {32'h0, 32'hDEADBEEF});
    end
    req0(0, 4'h0, 13'd0, 32'h0);
    req1(0, 4'h0, 13'd0, 32'h0);
    tick();
    // Tie in IDLE after r0 was last served
    req0(1, 4'h0, 13'd5, 32'h0);
    req1(1, 4'h0, 13'd7, 32'h0);
    #1;
`ifdef BRAM_ARB_RR_EN
    chk("tie_ready", {bus.r1_ready, bus.r0_ready}, 2'b10);
`else
    chk("tie_ready", {bus.r1_ready, bus.r0_ready}, 2'b01);
`endif
    tick();
    req0(0, 4'h0, 13'd0, 32'h0);
    req1(0, 4'h0, 13'd0, 32'h0);
    tick();
    tick();
    // Reset asserted at beat 2 of an r0 burst
    req0(1, 4'h0, 13'd5, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_en_ready", {bus.EN0, bus.r1_ready, bus.r0_ready}, 3'b000);
    chk("mrst_rvalid", {bus.r1_rvalid, bus.r0_rvalid}, 2'b00);
    chk("mrst_state", 64'(dut.state_q), 64'(bram_arb_pkg::IDLE));
    req0(0, 4'h0, 13'd0, 32'h0);
    rst_n = 1'b1;
    req1(1, 4'h0, 13'd7, 32'h0);
    #1;
    chk("post_rst_grant", {bus.r1_ready, bus.r0_ready, bus.EN0}, 3'b101);
    tick();
    chk("post_rst_resp", {bus.r1_rvalid, bus.r0_rvalid, bus.r1_rdata}, {2'b10, 32'h1122AB44});
    req1(0, 4'h0, 13'd0, 32'h0);
    tick();
    // Idle bus for 20 cycles
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("idle_ctl%0d", i), {bus.EN0, bus.r1_rvalid, bus.r0_rvalid}, 3'b000);
      chk($sformatf("idle_data%0d", i), {bus.r1_rdata, bus.r0_rdata}, 64'h0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester arbiter sharing the single-port 32-bit user BRAM between the Wishbone slave path (requester 0, firmware/exmem access) and the FIR data mover (requester 1). Accepts one access per cycle over a valid/ready handshake, drives the BRAM port (CLK/WE0/EN0/Di0/A0), and routes the one-cycle-latency read data back to the issuing requester with a tagged response pulse. It sits between the user-project bus logic and the `bram` instance. Bounded bursts keep per-word overhead low without starving either side.

## Interface
- ADDR_W, 13 — word-address width; must equal the BRAM depth exponent.
- BURST_MAX, 4 — maximum consecutive beats one requester keeps the grant while the other is waiting; range 1..15.
- CLK  in  1  — single clock; BRAM clock.
- RST_N  in  1  — reset, synchronous, active-low.
- r0_valid, r1_valid  in  1  — request present.
- r0_ready, r1_ready  out  1  — request accepted this cycle when valid&&ready.
- r0_we, r1_we  in  4  — byte write enables; 4'b0000 = read.
- r0_addr, r1_addr  in  ADDR_W  — word address.
- r0_wdata, r1_wdata  in  32  — write data.
- r0_rvalid, r1_rvalid  out  1  — one-cycle response pulse: read data valid, or write done.
- r0_rdata, r1_rdata  out  32  — read data; 0 when rvalid low.
- WE0  out  4, EN0  out  1, Di0  out  32, A0  out  32 — to BRAM; A0 = zero-extended word address.
- Do0  in  32 — from BRAM, registered, valid the cycle after EN0.

## Operation
- Grant FSM: IDLE, G0, G1; the state is the current owner.
- IDLE: if only one requester is valid, grant it. If both are valid, grant the priority winner (see Configuration).
- Gx: the owner's request passes through combinationally: EN0 = rx_valid, WE0/Di0/A0 from rx. rx_ready = 1 while in Gx.
- beat_cnt counts accepted beats in Gx.
- Leave Gx at the end of the cycle in which any of these holds:
  - rx_valid is low: go to G(other) if the other is valid, else IDLE.
  - beat_cnt reaches BURST_MAX−1 on an accepted beat and the other requester is valid: go to G(other), beat_cnt = 0.
- Otherwise stay. beat_cnt saturates when no competitor is waiting.
- In IDLE, grant and access happen in the same cycle: the IDLE→Gx decision is combinational and the first beat issues immediately. No bubble.
- The non-owner's ready is always 0.
- Response tracker (registered, 1 deep):
  - resp_v = accepted beat.
  - resp_id = owner.
  - resp_rd = (we == 0).
- Next cycle:
  - r{resp_id}_rvalid = resp_v.
  - r{resp_id}_rdata = resp_rd ? Do0 : 0.
  - The other requester's rvalid and rdata are 0.
- Writes: the BRAM also returns old data on Do0. The arbiter discards it; rdata stays 0 on a write response.
- Partial-byte writes pass through unmodified.

## Timing
- Access latency: request accepted at cycle T → rvalid and rdata at T+1. Throughput is 1 beat/cycle.
- Owner switch costs 0 cycles. The other requester's first beat is issued the cycle after the last beat of the old owner.
- Reset values:
  - FSM = IDLE, beat_cnt = 0, resp_v = 0, RR pointer = 0.
  - All ready, rvalid, rdata = 0.
  - EN0 = 0, WE0 = 0.
  - Di0 and A0 are combinational from the FSM: 0 in IDLE with no valid request.
- Reset asserted mid-burst: on the next edge everything returns to the reset values, and an in-flight response is dropped (no rvalid). Requesters must reissue.
- Simultaneous valid in IDLE: exactly one ready asserts. Never both.

## Configuration
- BRAM_ARB_RR_EN defined: round-robin. A 1-bit pointer names the last granted requester. A tie in IDLE goes to the other one. The pointer updates on every grant.
- Undefined: fixed priority, requester 0 (Wishbone) wins ties. BURST_MAX still bounds requester 1 when requester 0 waits. Requester 0 is also limited by BURST_MAX, which prevents total starvation of the FIR mover.

## Structure
- Shared package bram_arb_pkg:
  - state enum (IDLE/G0/G1).
  - requester ID type (1 bit).
  - default BURST_MAX.
  - a BRAM_WE_READ = 4'b0000 constant.
- One sub-module: bram_arb_resp. It holds the response register and rdata/rvalid demux, so the FSM stays purely combinational-select plus state.

## Test plan
- Single read: preload RAM[5]=32'hDEADBEEF. r0 reads addr 5 → r0_ready at T, r0_rvalid=1 with r0_rdata=32'hDEADBEEF at T+1, r1_rvalid=0.
- Byte write: r1 writes we=4'b0010, wdata=32'h0000AB00 to addr 7 (old 32'h11223344), then reads 7 → rdata 32'h1122AB44. The write response has rdata=0.
- Contention, BURST_MAX=4: both hold valid for 10 beats → grant sequence 0000 1111 00 (RR or fixed). Each rvalid goes to the correct requester, with 0 gaps on EN0.
- Tie in IDLE after r0 was last served: with BRAM_ARB_RR_EN, r1 wins. Without it, r0 wins.
- Reset mid-burst: RST_N low at beat 2 of r0's burst → next cycle EN0=0, all rvalid=0, FSM IDLE. After release, r1 alone gets the grant immediately.
- Idle bus: no valid for 20 cycles → EN0=0, all rdata=0 throughout.
